// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: trace buffer for architectural write events (GRF writeback, DM store).
// Events are queued in program order, with the GRF event ahead of the DM event when both occur
// in the same cycle. The buffer never back-pressures the core. Events that do not fit are
// dropped; each drop sets the sticky overflow flag and is tallied in a saturating counter.
// The read side is first-word fall-through with a valid/ready handshake.
module wb_trace_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          grf_we,
   input  logic [31:0]   grf_pc,
   input  logic [4:0]    grf_addr,
   input  logic [31:0]   grf_data,
   input  logic          dm_we,
   input  logic [31:0]   dm_pc,
   input  logic [31:0]   dm_addr,
   input  logic [31:0]   dm_data,
   input  logic          rd_ready,
   output logic          rd_valid,
   output logic          rd_kind,
   output logic [31:0]   rd_pc,
   output logic [31:0]   rd_addr,
   output logic [31:0]   rd_data,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic [15:0]   drop_cnt
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic        kind;
      logic [31:0] pc;
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   entry_t mem [0:DEPTH-1];

   logic [AW-1:0] wptr_reg, rptr_reg;
   logic [AW:0]   count_reg;
   logic          overflow_reg;
   logic [15:0]   drop_cnt_reg;

   logic          grf_ev, dm_ev, grf_acc, dm_acc, pop;
   logic [AW:0]   free;
   logic [AW:0]   count_next;
   logic [AW-1:0] wptr_next, rptr_next, dm_wptr;
   logic [1:0]    n_drop;
   logic [16:0]   drop_sum;
   entry_t        grf_entry, dm_entry;

   // Event qualification and admission; space is judged before this cycle's pop,
   // so a slot freed by a pop is never reused in the same cycle.
   always_comb begin
      grf_ev     = grf_we && (grf_addr != 5'd0);
      dm_ev      = dm_we;
      free       = FULL - count_reg;
      grf_acc    = grf_ev && (free != '0);
      dm_acc     = dm_ev && ((free >= (AW+1)'(2)) || ((free == (AW+1)'(1)) && !grf_ev));
      n_drop     = {1'b0, grf_ev && !grf_acc} + {1'b0, dm_ev && !dm_acc};
      pop        = (count_reg != '0) && rd_ready;
      dm_wptr    = wptr_reg + AW'(grf_acc);
      wptr_next  = wptr_reg + AW'(grf_acc) + AW'(dm_acc);
      rptr_next  = rptr_reg + AW'(pop);
      count_next = count_reg + (AW+1)'(grf_acc) + (AW+1)'(dm_acc) - (AW+1)'(pop);
      drop_sum   = {1'b0, drop_cnt_reg} + {15'd0, n_drop};

      grf_entry.kind = 1'b0;
      grf_entry.pc   = grf_pc;
      grf_entry.addr = {27'd0, grf_addr};
      grf_entry.data = grf_data;
      dm_entry.kind  = 1'b1;
      dm_entry.pc    = dm_pc;
      dm_entry.addr  = dm_addr;
      dm_entry.data  = dm_data;
   end

   // Entry storage: GRF lands at wptr, DM lands right behind it when both are accepted.
   always_ff @(posedge clk) begin
      if (grf_acc)
         mem[wptr_reg] <= grf_entry;
      if (dm_acc)
         mem[dm_wptr] <= dm_entry;
   end

   // Pointers, occupancy and drop bookkeeping; full/empty come from count alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_reg     <= '0;
         rptr_reg     <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         wptr_reg  <= wptr_next;
         rptr_reg  <= rptr_next;
         count_reg <= count_next;
         if (n_drop != 2'd0)
            overflow_reg <= 1'b1;
         drop_cnt_reg <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   // Fall-through read port: the head entry is presented directly from storage.
   always_comb begin
      rd_valid = (count_reg != '0);
      rd_kind  = mem[rptr_reg].kind;
      rd_pc    = mem[rptr_reg].pc;
      rd_addr  = mem[rptr_reg].addr;
      rd_data  = mem[rptr_reg].data;
      count    = count_reg;
      overflow = overflow_reg;
      drop_cnt = drop_cnt_reg;
   end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: a queue-based reference model plus directed literal checks and
// randomized traffic. Outputs are compared on every falling edge.
module tb_wb_trace_fifo;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        grf_we, dm_we, rd_ready;
   logic [31:0] grf_pc, grf_data, dm_pc, dm_addr, dm_data;
   logic [4:0]  grf_addr;
   logic        rd_valid, rd_kind, overflow;
   logic [31:0] rd_pc, rd_addr, rd_data;
   logic [AW:0] count;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_data(grf_data),
      .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_data(dm_data),
      .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_kind(rd_kind), .rd_pc(rd_pc),
      .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .overflow(overflow),
      .drop_cnt(drop_cnt)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: entries are {kind, pc, addr, data}
   logic [96:0] mq[$];
   logic [96:0] ev[$];
   bit          m_ovf;
   int          m_drop;
   int          free_slots;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model update: space judged before the pop, GRF offered before DM, overflow events dropped
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_drop = 0;
      end else begin
         free_slots = DEPTH - mq.size();
         ev.delete();
         if (grf_we && grf_addr != 5'd0)
            ev.push_back({1'b0, grf_pc, 27'd0, grf_addr, grf_data});
         if (dm_we)
            ev.push_back({1'b1, dm_pc, dm_addr, dm_data});
         if (mq.size() != 0 && rd_ready) begin
            $display("pop kind=%0d pc=%h addr=%h data=%h", mq[0][96], mq[0][95:64],
                     mq[0][63:32], mq[0][31:0]);
            void'(mq.pop_front());
         end
         foreach (ev[i]) begin
            if (i < free_slots)
               mq.push_back(ev[i]);
            else begin
               m_ovf = 1'b1;
               if (m_drop < 65535)
                  m_drop++;
            end
         end
      end
   end

   // Compare process: every falling edge outside reset
   always @(negedge clk) begin
      if (!reset) begin
         chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
         chk("count", 32'(count), mq.size());
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("drop_cnt", 32'(drop_cnt), m_drop);
         if (mq.size() != 0) begin
            chk("rd_kind", 32'(rd_kind), 32'(mq[0][96]));
            chk("rd_pc", rd_pc, mq[0][95:64]);
            chk("rd_addr", rd_addr, mq[0][63:32]);
            chk("rd_data", rd_data, mq[0][31:0]);
         end
      end
   end

   task automatic drive(input bit g, input logic [4:0] ga, input logic [31:0] gp,
                        input logic [31:0] gd, input bit d, input logic [31:0] dp,
                        input logic [31:0] da, input logic [31:0] dd, input bit rdy);
      grf_we = g; grf_addr = ga; grf_pc = gp; grf_data = gd;
      dm_we = d; dm_pc = dp; dm_addr = da; dm_data = dd;
      rd_ready = rdy;
   endtask

   task automatic idle();
      drive(0, 5'd0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 32'd0, 0);
   endtask

   task automatic pop_one();
      drive(0, 5'd0, 32'd0, 32'd0, 0, 32'd0, 32'd0, 32'd0, 1);
      @(negedge clk);
      idle();
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("t0_valid", 32'(rd_valid), 32'd0);
      chk("t0_count", 32'(count), 32'd0);
      chk("t0_ovf", 32'(overflow), 32'd0);
      chk("t0_drop", 32'(drop_cnt), 32'd0);

      // Single GRF event, then pop
      drive(1, 5'd5, 32'h3000, 32'h1234, 0, 32'd0, 32'd0, 32'd0, 0);
      @(negedge clk);
      idle();
      chk("t1_valid", 32'(rd_valid), 32'd1);
      chk("t1_kind", 32'(rd_kind), 32'd0);
      chk("t1_pc", rd_pc, 32'h3000);
      chk("t1_addr", rd_addr, 32'd5);
      chk("t1_data", rd_data, 32'h1234);
      chk("t1_count", 32'(count), 32'd1);
      pop_one();
      chk("t1_pop_valid", 32'(rd_valid), 32'd0);
      chk("t1_pop_count", 32'(count), 32'd0);

      // Write to r0 is not an event
      drive(1, 5'd0, 32'h3010, 32'hFFFF, 0, 32'd0, 32'd0, 32'd0, 0);
      @(negedge clk);
      idle();
      chk("t2_valid", 32'(rd_valid), 32'd0);
      chk("t2_count", 32'(count), 32'd0);
      chk("t2_ovf", 32'(overflow), 32'd0);

      // Same-cycle GRF + DM: GRF first
      drive(1, 5'd8, 32'h3004, 32'hAAAA, 1, 32'h3008, 32'h10, 32'hBBBB, 0);
      @(negedge clk);
      idle();
      chk("t3_count", 32'(count), 32'd2);
      chk("t3_kind0", 32'(rd_kind), 32'd0);
      chk("t3_pc0", rd_pc, 32'h3004);
      pop_one();
      chk("t3_kind1", 32'(rd_kind), 32'd1);
      chk("t3_pc1", rd_pc, 32'h3008);
      chk("t3_addr1", rd_addr, 32'h10);
      pop_one();
      chk("t3_empty", 32'(count), 32'd0);

      // 17 pushes into 16 slots: last one dropped
      for (int i = 1; i <= 17; i++) begin
         drive(1, 5'(i), 32'h4000 + 32'(4 * i), 32'(i), 0, 32'd0, 32'd0, 32'd0, 0);
         @(negedge clk);
      end
      idle();
      chk("t4_count", 32'(count), 32'd16);
      chk("t4_ovf", 32'(overflow), 32'd1);
      chk("t4_drop", 32'(drop_cnt), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         chk("t4_order", rd_data, 32'(i));
         pop_one();
      end
      chk("t4_drained", 32'(rd_valid), 32'd0);

      // Dual event with one free slot, and push+pop on a full buffer
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive(1, 5'(i + 1), 32'h6000 + 32'(4 * i), 32'h600 + 32'(i), 0, 32'd0, 32'd0, 32'd0, 0);
         @(negedge clk);
      end
      idle();
      chk("t5_count15", 32'(count), 32'd15);
      drive(1, 5'd3, 32'h6100, 32'h61, 1, 32'h6104, 32'h80, 32'h62, 1);
      @(negedge clk);
      idle();
      chk("t5_dual_count", 32'(count), 32'd15);
      chk("t5_dual_drop", 32'(drop_cnt), 32'd1);
      chk("t5_dual_ovf", 32'(overflow), 32'd1);
      drive(1, 5'd4, 32'h6200, 32'h63, 0, 32'd0, 32'd0, 32'd0, 0);
      @(negedge clk);
      idle();
      chk("t5_full", 32'(count), 32'd16);
      drive(1, 5'd6, 32'h6300, 32'h64, 0, 32'd0, 32'd0, 32'd0, 1);
      @(negedge clk);
      idle();
      chk("t5_fullpp_count", 32'(count), 32'd15);
      chk("t5_fullpp_drop", 32'(drop_cnt), 32'd2);
      repeat (15) pop_one();
      chk("t5_drained", 32'(count), 32'd0);

      // 40 events with continuous pop: pointers wrap twice, nothing dropped
      do_reset();
      for (int i = 0; i < 40; i++) begin
         if (i > 0)
            chk("t6_order", rd_data, 32'hC000 + 32'(i - 1));
         drive(1, 5'((i % 31) + 1), 32'h5000 + 32'(4 * i), 32'hC000 + 32'(i),
               0, 32'd0, 32'd0, 32'd0, 1);
         @(negedge clk);
      end
      chk("t6_last", rd_data, 32'hC000 + 32'd39);
      pop_one();
      chk("t6_empty", 32'(count), 32'd0);
      chk("t6_drop", 32'(drop_cnt), 32'd0);
      chk("t6_ovf", 32'(overflow), 32'd0);

      // Randomized traffic with varying consumer rates
      for (int blk = 0; blk < 3; blk++) begin
         for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 99) < 60,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom,
                  $urandom_range(0, 99) < 40, $urandom, $urandom, $urandom,
                  $urandom_range(0, 99) < ((blk == 0) ? 15 : (blk == 1) ? 85 : 50));
            @(negedge clk);
         end
      end

      // Asynchronous reset in the middle of a cycle, with events still being offered
      drive(1, 5'd9, 32'h7000, 32'h70, 1, 32'h7004, 32'h74, 32'h75, 0);
      #2 reset = 1'b1;
      #1;
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle();
      @(negedge clk);
      chk("rst_after_count", 32'(count), 32'd0);

      // Drop counter saturation
      do_reset();
      drive(1, 5'd1, 32'h8000, 32'h80, 1, 32'h8004, 32'h84, 32'h85, 0);
      repeat (32780) @(negedge clk);
      idle();
      chk("sat_drop", 32'(drop_cnt), 32'h0000FFFF);
      chk("sat_ovf", 32'(overflow), 32'd1);
      chk("sat_count", 32'(count), 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
